// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg
// Definitions shared by the data-memory responder and its lane aligner.
//   mem_access_size_t  : access size carried by a MEM-stage request
//   dmem_resp_state_t  : responder FSM state, with DMEM_* state constants
//   access_bytes()     : number of bytes touched by an access size
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        MEM_ACCESS_SIZE_BYTE = 2'd0,
        MEM_ACCESS_SIZE_HALF = 2'd1,
        MEM_ACCESS_SIZE_WORD = 2'd2
    } mem_access_size_t;

    typedef logic [2:0] dmem_resp_state_t;

    localparam dmem_resp_state_t DMEM_IDLE    = 3'd0;
    localparam dmem_resp_state_t DMEM_ISSUE_A = 3'd1;
    localparam dmem_resp_state_t DMEM_ISSUE_B = 3'd2;
    localparam dmem_resp_state_t DMEM_CAPTURE = 3'd3;
    localparam dmem_resp_state_t DMEM_RESP    = 3'd4;

    // The spare size encoding behaves like a full word access.
    function automatic logic [2:0] access_bytes(input mem_access_size_t size);
        case (size)
            MEM_ACCESS_SIZE_BYTE: access_bytes = 3'd1;
            MEM_ACCESS_SIZE_HALF: access_bytes = 3'd2;
            default:              access_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/dmem_responder_lane_align.sv
// dmem_lane_align
// Purely combinational byte-lane alignment for one request.
//   offset      in  : byte offset within the first word (addr[1:0])
//   size        in  : access size
//   wr_data     in  : store data, right-aligned
//   byte_mask   out : 8-bit lane mask spanning word A (low) and word B (high)
//   wide_wdata  out : store data shifted into its lanes across both words
//   split       out : the access touches word B
//   rd_shift    out : bit shift that right-aligns load data from {rdB, rdA}
//   rd_keep     out : mask keeping only the requested number of load bytes
module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic [1:0]       offset,
    input  mem_access_size_t size,
    input  logic [31:0]      wr_data,
    output logic [7:0]       byte_mask,
    output logic [63:0]      wide_wdata,
    output logic             split,
    output logic [4:0]       rd_shift,
    output logic [31:0]      rd_keep
);

    logic [7:0] base_mask;

    // Build the unshifted lane mask from the access size, then slide the
    // mask and data up by the byte offset; anything past lane 3 spills into
    // the second word, which is exactly what makes an access split.
    always_comb begin
        base_mask = 8'h0F;
        rd_keep   = 32'hFFFF_FFFF;
        case (access_bytes(size))
            3'd1: begin
                base_mask = 8'h01;
                rd_keep   = 32'h0000_00FF;
            end
            3'd2: begin
                base_mask = 8'h03;
                rd_keep   = 32'h0000_FFFF;
            end
            default: begin
                base_mask = 8'h0F;
                rd_keep   = 32'hFFFF_FFFF;
            end
        endcase
        byte_mask  = base_mask << offset;
        wide_wdata = {32'b0, wr_data} << {offset, 3'b000};
        split      = |byte_mask[7:4];
        rd_shift   = {offset, 3'b000};
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder
// Memory-side responder for MEM-stage data requests. Each byte/half/word
// request becomes one or two word accesses on a synchronous single-port SRAM
// with byte enables; accesses crossing a word boundary are split in two.
// Load data returns right-aligned and zero-extended (WB sign-extends).
//   clk_i, reset_ni        : clock, synchronous active-low reset
//   req_valid_i/ready_o    : request handshake (ready only while idle)
//   req_addr_i/size_i      : byte address and access size
//   req_wr_enable_i/data_i : store flag and right-aligned store data
//   rsp_valid_o            : one-cycle completion pulse for loads and stores
//   rsp_rd_data_o          : load result, held until the next response
//   sram_*                 : SRAM port; read data arrives one cycle after en
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
)
(
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  mem_access_size_t      req_size_i,
    input  logic                  req_wr_enable_i,
    input  logic [31:0]           req_wr_data_i,
    output logic                  rsp_valid_o,
    output logic [31:0]           rsp_rd_data_o,
    output logic                  sram_en_o,
    output logic                  sram_we_o,
    output logic [ADDR_WIDTH-3:0] sram_addr_o,
    output logic [3:0]            sram_be_o,
    output logic [31:0]           sram_wdata_o,
    input  logic [31:0]           sram_rdata_i
);

    localparam int WORD_ADDR_WIDTH = ADDR_WIDTH - 2;

    dmem_resp_state_t      state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    mem_access_size_t      size_q;
    logic                  wr_q;
    logic [31:0]           wr_data_q;
    logic [31:0]           rd_a_q;
    logic [31:0]           rsp_rd_data_q;

    logic [7:0]            byte_mask;
    logic [63:0]           wide_wdata;
    logic                  split;
    logic [4:0]            rd_shift;
    logic [31:0]           rd_keep;

    logic [WORD_ADDR_WIDTH-1:0] word_a;
    logic [WORD_ADDR_WIDTH-1:0] word_b;
    logic [63:0]                rd_combined;
    logic [31:0]                load_value;

    // Lane alignment works from the registered request so the request
    // inputs are free to change once the handshake has happened.
    dmem_lane_align u_lane_align (
        .offset     (addr_q[1:0]),
        .size       (size_q),
        .wr_data    (wr_data_q),
        .byte_mask  (byte_mask),
        .wide_wdata (wide_wdata),
        .split      (split),
        .rd_shift   (rd_shift),
        .rd_keep    (rd_keep)
    );

    assign word_a = addr_q[ADDR_WIDTH-1:2];
    assign word_b = word_a + WORD_ADDR_WIDTH'(1);

    assign req_ready_o   = (state_q == DMEM_IDLE);
    assign rsp_valid_o   = (state_q == DMEM_RESP);
    assign rsp_rd_data_o = rsp_rd_data_q;

    // The SRAM port is only live during the two issue states; everywhere
    // else it is held quiet so a stray enable can never corrupt memory.
    always_comb begin
        sram_en_o    = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_be_o    = 4'b0000;
        sram_wdata_o = 32'b0;
        case (state_q)
            DMEM_ISSUE_A: begin
                sram_en_o    = 1'b1;
                sram_we_o    = wr_q;
                sram_addr_o  = word_a;
                sram_be_o    = byte_mask[3:0];
                sram_wdata_o = wide_wdata[31:0];
            end
            DMEM_ISSUE_B: begin
                sram_en_o    = 1'b1;
                sram_we_o    = wr_q;
                sram_addr_o  = word_b;
                sram_be_o    = byte_mask[7:4];
                sram_wdata_o = wide_wdata[63:32];
            end
            default: begin
                sram_en_o = 1'b0;
            end
        endcase
    end

    // In CAPTURE the SRAM is presenting the last word read. For a split
    // access that is word B and word A was stashed a cycle earlier; for a
    // single access it is word A and the upper half is zero.
    always_comb begin
        rd_combined = split ? {sram_rdata_i, rd_a_q} : {32'b0, sram_rdata_i};
        load_value  = 32'(rd_combined >> rd_shift) & rd_keep;
    end

    // Request sequencer: accept, issue one or two SRAM accesses, capture the
    // returning data, then pulse the response. Requests arriving while busy
    // are simply not accepted; nothing is queued.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q       <= DMEM_IDLE;
            addr_q        <= '0;
            size_q        <= MEM_ACCESS_SIZE_BYTE;
            wr_q          <= 1'b0;
            wr_data_q     <= 32'b0;
            rd_a_q        <= 32'b0;
            rsp_rd_data_q <= 32'b0;
        end else begin
            case (state_q)
                DMEM_IDLE: begin
                    if (req_valid_i) begin
                        addr_q    <= req_addr_i;
                        size_q    <= req_size_i;
                        wr_q      <= req_wr_enable_i;
                        wr_data_q <= req_wr_data_i;
                        state_q   <= DMEM_ISSUE_A;
                    end
                end
                DMEM_ISSUE_A: begin
                    state_q <= split ? DMEM_ISSUE_B : DMEM_CAPTURE;
                end
                DMEM_ISSUE_B: begin
                    rd_a_q  <= sram_rdata_i;
                    state_q <= DMEM_CAPTURE;
                end
                DMEM_CAPTURE: begin
                    rsp_rd_data_q <= wr_q ? 32'b0 : load_value;
                    state_q       <= DMEM_RESP;
                end
                DMEM_RESP: begin
                    state_q <= DMEM_IDLE;
                end
                default: begin
                    state_q <= DMEM_IDLE;
                end
            endcase
        end
    end

endmodule
